// File: rtl/jk_seq_pkg.sv
// Shared op codes and FSM state encodings for the JK bank sequencer.
// Also used by jk_next_model and jk_bank_sequencer.
package jk_seq_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_RSTALL = 3'd1;
  localparam logic [2:0] OP_SETALL = 3'd2;
  localparam logic [2:0] OP_CLR    = 3'd3;
  localparam logic [2:0] OP_PRE    = 3'd4;
  localparam logic [2:0] OP_TGL    = 3'd5;
  localparam logic [2:0] OP_COUNT  = 3'd6;
  localparam logic [2:0] OP_NOP    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/jk_next_model.sv
// Combinational model of one bank cycle: J/K/CE/R/S drive for an op and the
// resulting expected bank state.
module jk_next_model
  import jk_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] exp_q,
  output logic [N-1:0] exp_next,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic [N-1:0] ce,
  output logic         r,
  output logic         s
);

  // carry[i] is high when every lower bit is one: the ripple-counter toggle term.
  logic [N-1:0] carry;
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_carry
      assign carry[gi] = carry[gi-1] & exp_q[gi-1];
    end
  endgenerate

  always_comb begin
    exp_next = exp_q;
    j        = '0;
    k        = '0;
    ce       = '0;
    r        = 1'b0;
    s        = 1'b0;
    case (op)
      OP_HOLD: begin
        ce = mask;
      end
      OP_RSTALL: begin
        r        = 1'b1;
        exp_next = '0;
      end
      OP_SETALL: begin
        s        = 1'b1;
        exp_next = '1;
      end
      OP_CLR: begin
        ce       = mask;
        k        = mask;
        exp_next = exp_q & ~mask;
      end
      OP_PRE: begin
        ce       = mask;
        j        = mask;
        exp_next = exp_q | mask;
      end
      OP_TGL: begin
        ce       = mask;
        j        = mask;
        k        = mask;
        exp_next = exp_q ^ mask;
      end
      OP_COUNT: begin
        ce       = '1;
        j        = carry;
        k        = carry;
        exp_next = exp_q ^ carry;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of N JK cells with an expected-state model.
// Define JKSEQ_CHECK_EN to enable the sticky Qout-vs-model mismatch flags.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = 5
) (
  input  logic          Clk,
  input  logic          R,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [N-1:0]  cmd_mask,
  input  logic [LW-1:0] cmd_len,
  input  logic [N-1:0]  q_fb,
  output logic [N-1:0]  jk_j,
  output logic [N-1:0]  jk_k,
  output logic [N-1:0]  jk_ce,
  output logic          jk_r,
  output logic          jk_s,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  err_bits
);

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  exp_q, exp_d;

  logic [N-1:0]  m_exp, m_j, m_k, m_ce;
  logic          m_r, m_s;

  jk_next_model #(.N(N)) u_model (
    .op       (op_q),
    .mask     (mask_q),
    .exp_q    (exp_q),
    .exp_next (m_exp),
    .j        (m_j),
    .k        (m_k),
    .ce       (m_ce),
    .r        (m_r),
    .s        (m_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mask_d  = mask_q;
    exp_d   = exp_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          mask_d  = cmd_mask;
          cnt_d   = (cmd_len == '0) ? LW'(1) : cmd_len;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        exp_d = m_exp;
        if (cnt_q == LW'(1)) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      mask_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
    end
  end

  // R overrides every output in the same cycle so the cells clear with the model.
  logic run_act, chk_act;
  assign run_act = (state_q == ST_RUN) && !R;
  assign chk_act = (state_q == ST_CHECK) && !R;

  assign jk_j      = run_act ? m_j  : '0;
  assign jk_k      = run_act ? m_k  : '0;
  assign jk_ce     = run_act ? m_ce : '0;
  assign jk_r      = R | (run_act & m_r);
  assign jk_s      = run_act & m_s;
  assign busy      = run_act | chk_act;
  assign done      = chk_act;
  assign cmd_ready = R | (state_q == ST_IDLE);

`ifdef JKSEQ_CHECK_EN
  logic         err_q, err_d;
  logic [N-1:0] err_bits_q, err_bits_d;
  logic [N-1:0] diff;

  assign diff = q_fb ^ exp_q;

  always_comb begin
    err_d      = err_q;
    err_bits_d = err_bits_q;
    if (state_q == ST_CHECK) begin
      err_d      = err_q | (|diff);
      err_bits_d = err_bits_q | diff;
    end
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      err_q      <= 1'b0;
      err_bits_q <= '0;
    end else begin
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
    end
  end

  assign err      = err_q & ~R;
  assign err_bits = R ? '0 : err_bits_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
  assign err      = 1'b0;
  assign err_bits = '0;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer (N=4, LW=5); the JKSEQ_CHECK_EN section
// runs only when that macro is defined.
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  logic       Clk = 1'b0;
  logic       R = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_mask = 4'd0;
  logic [4:0] cmd_len = 5'd0;
  logic [3:0] q_fb = 4'd0;
  logic [3:0] jk_j, jk_k, jk_ce;
  logic       jk_r, jk_s, busy, done, err;
  logic [3:0] err_bits;

  int checks = 0;
  int failures = 0;

  jk_bank_sequencer #(.N(4), .LW(5)) dut (
    .Clk(Clk), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .q_fb(q_fb),
    .jk_j(jk_j), .jk_k(jk_k), .jk_ce(jk_ce), .jk_r(jk_r), .jk_s(jk_s),
    .busy(busy), .done(done), .err(err), .err_bits(err_bits)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, expv);
    end else begin
      $display("ok   %s = 0x%0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present a command in IDLE; returns in the first RUN cycle.
  task automatic send(input string tag, input logic [2:0] op, input logic [3:0] mask, input logic [4:0] len);
    check_val({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  // Checks {J,K,CE,r,s} and busy for one RUN cycle, then advances.
  task automatic drv(input string tag, input logic [13:0] expv);
    check_val(tag, 32'({jk_j, jk_k, jk_ce, jk_r, jk_s}), 32'(expv));
    check_val({tag, ".busy"}, 32'(busy), 32'd1);
    step();
  endtask

  // Called in the CHECK cycle: verifies done/ready timing and final model state.
  task automatic fin(input string tag, input logic [3:0] expq, input logic [3:0] qfb);
    q_fb = qfb;
    check_val({tag, ".done"}, 32'({done, cmd_ready, busy}), 32'b101);
    step();
    check_val({tag, ".idle"}, 32'({done, cmd_ready, busy}), 32'b010);
    check_val({tag, ".exp"}, 32'(dut.exp_q), 32'(expq));
  endtask

  initial begin
    // 1. reset held for two cycles
    R = 1'b1;
    step();
    step();
    check_val("rst.jk_r", 32'(jk_r), 32'd1);
    check_val("rst.ready", 32'(cmd_ready), 32'd1);
    check_val("rst.outs", 32'({jk_j, jk_k, jk_ce, jk_s, busy, done, err}), 32'd0);
    check_val("rst.exp", 32'(dut.exp_q), 32'd0);
    R = 1'b0;
    step();
    check_val("rst.release", 32'({jk_r, cmd_ready, busy}), 32'b010);

    // 2. PRE mask=0101 len=1
    send("pre", OP_PRE, 4'b0101, 5'd1);
    drv("pre.c1", {4'b0101, 4'b0000, 4'b0101, 2'b00});
    fin("pre", 4'b0101, 4'b0101);

    // 3. COUNT len=5 from 0000
    send("rst1", OP_RSTALL, 4'b0000, 5'd1);
    drv("rst1.c1", {4'b0000, 4'b0000, 4'b0000, 2'b10});
    fin("rst1", 4'b0000, 4'b0000);
    send("cnt5", OP_COUNT, 4'b0000, 5'd5);
    drv("cnt5.c1", {4'b0001, 4'b0001, 4'b1111, 2'b00});
    drv("cnt5.c2", {4'b0011, 4'b0011, 4'b1111, 2'b00});
    drv("cnt5.c3", {4'b0001, 4'b0001, 4'b1111, 2'b00});
    drv("cnt5.c4", {4'b0111, 4'b0111, 4'b1111, 2'b00});
    drv("cnt5.c5", {4'b0001, 4'b0001, 4'b1111, 2'b00});
    fin("cnt5", 4'b0101, 4'b0101);

    // COUNT len=17 from 0000 wraps once
    send("rst2", OP_RSTALL, 4'b1111, 5'd1);
    step();
    fin("rst2", 4'b0000, 4'b0000);
    send("cnt17", OP_COUNT, 4'b1010, 5'd17);
    for (int i = 0; i < 17; i++) step();
    fin("cnt17", 4'b0001, 4'b0001);

    // 4. SETALL len=0 acts as one cycle, then TGL 1111 twice
    send("set", OP_SETALL, 4'b0000, 5'd0);
    drv("set.c1", {4'b0000, 4'b0000, 4'b0000, 2'b01});
    fin("set", 4'b1111, 4'b1111);
    send("tgl", OP_TGL, 4'b1111, 5'd2);
    drv("tgl.c1", {4'b1111, 4'b1111, 4'b1111, 2'b00});
    drv("tgl.c2", {4'b1111, 4'b1111, 4'b1111, 2'b00});
    fin("tgl", 4'b1111, 4'b1111);

    // CLR, HOLD and NOP from 1111
    send("clr", OP_CLR, 4'b0011, 5'd1);
    drv("clr.c1", {4'b0000, 4'b0011, 4'b0011, 2'b00});
    fin("clr", 4'b1100, 4'b1100);
    send("hold", OP_HOLD, 4'b1010, 5'd1);
    drv("hold.c1", {4'b0000, 4'b0000, 4'b1010, 2'b00});
    fin("hold", 4'b1100, 4'b1100);
    send("nop", OP_NOP, 4'b1111, 5'd1);
    drv("nop.c1", 14'd0);
    fin("nop", 4'b1100, 4'b1100);

    // cmd_valid pulse while busy must be ignored
    send("tgl3", OP_TGL, 4'b0110, 5'd3);
    drv("tgl3.c1", {4'b0110, 4'b0110, 4'b0110, 2'b00});
    cmd_valid = 1'b1;
    cmd_op    = OP_PRE;
    cmd_mask  = 4'b1111;
    check_val("busy.ready", 32'(cmd_ready), 32'd0);
    drv("tgl3.c2", {4'b0110, 4'b0110, 4'b0110, 2'b00});
    cmd_valid = 1'b0;
    drv("tgl3.c3", {4'b0110, 4'b0110, 4'b0110, 2'b00});
    fin("tgl3", 4'b1010, 4'b1010);
    check_val("tgl3.noaccept", 32'(busy), 32'd0);

`ifdef JKSEQ_CHECK_EN
    // 5. mismatch in CHECK sets sticky flags
    send("pre2", OP_PRE, 4'b0101, 5'd1);
    step();
    fin("pre2", 4'b1111, 4'b1011);
    check_val("chk.err", 32'({err, err_bits}), 32'b1_0100);
    send("hold2", OP_HOLD, 4'b0000, 5'd1);
    step();
    fin("hold2", 4'b1111, 4'b1111);
    check_val("chk.sticky", 32'({err, err_bits}), 32'b1_0100);
`else
    check_val("nochk.err", 32'({err, err_bits}), 32'd0);
`endif

    // 6. reset in 3rd cycle of COUNT len=8 aborts without done
    send("rst3", OP_RSTALL, 4'b0000, 5'd1);
    step();
    fin("rst3", 4'b0000, 4'b0000);
    send("abort", OP_COUNT, 4'b0000, 5'd8);
    drv("abort.c1", {4'b0001, 4'b0001, 4'b1111, 2'b00});
    drv("abort.c2", {4'b0011, 4'b0011, 4'b1111, 2'b00});
    R = 1'b1;
    #1;
    check_val("abort.rcycle", 32'({jk_r, jk_s, busy, done, cmd_ready}), 32'b10001);
    check_val("abort.drv", 32'({jk_j, jk_k, jk_ce}), 32'd0);
    step();
    R = 1'b0;
    #1;
    check_val("abort.exp", 32'(dut.exp_q), 32'd0);
    check_val("abort.idle", 32'({busy, done, cmd_ready, err, err_bits}), 32'b0010_0000);
    step();
    check_val("abort.nodone", 32'({busy, done, cmd_ready}), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
